// File: rtl/bch_chien_locator_par.sv
// Parallel Chien-search error locator: evaluates sigma at PAR positions per beat.
// Ports: clk, rst_n (async low), start/sigma in; accepted back-pressure;
//        busy/valid/first/last/err/err_count/uncorr out.
// Optional macro BCH_CHIEN_UNCORR_DETECT_EN enables degree-vs-count uncorr flag.
module bch_chien_locator_par #(
    parameter int           M         = 4,
    parameter int           N         = 15,
    parameter int           T         = 2,
    parameter int           PAR       = 1,
    parameter logic [M:0]   PRIM_POLY = 5'b10011
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [(T+1)*M-1:0]       sigma,
    input  logic                     accepted,
    output logic                     busy,
    output logic                     valid,
    output logic                     first,
    output logic                     last,
    output logic [PAR-1:0]           err,
    output logic [$clog2(N+1)-1:0]   err_count,
    output logic                     uncorr
);

    localparam int Q     = (1 << M) - 1;
    localparam int SHIFT = (1 << M) - N;
    localparam int BEATS = (N + PAR - 1) / PAR;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CW    = $clog2(N + 1);

    // x * alpha, reduced by the primitive polynomial
    function automatic logic [M-1:0] mul_alpha(input logic [M-1:0] x);
        logic [M:0] s;
        s = {x, 1'b0};
        if (s[M]) s = s ^ PRIM_POLY;
        return s[M-1:0];
    endfunction

    function automatic logic [M-1:0] alpha_pow(input int e);
        logic [M-1:0] r;
        r    = '0;
        r[0] = 1'b1;
        for (int k = 0; k < (e % Q); k++) r = mul_alpha(r);
        return r;
    endfunction

    // x * alpha^e with e constant at every call site: pure XOR network
    function automatic logic [M-1:0] mulc(input logic [M-1:0] x, input int e);
        logic [M-1:0] r;
        r = '0;
        for (int j = 0; j < M; j++)
            if (x[j]) r = r ^ alpha_pow(e + j);
        return r;
    endfunction

    logic [T:0][M-1:0] term_q, term_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic              first_q, first_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [PAR-1:0]    err_w;
    logic [CW-1:0]     pc;
    logic              last_w;
    logic              load, adv;

    assign last_w = valid_q && (beat_q == BW'(BEATS - 1));
    assign load   = start && !busy_q;
    assign adv    = valid_q && accepted;

    // Lane l sums term_i * alpha^(i*l); lanes past the codeword end are masked
    always_comb begin
        logic [M-1:0] sum;
        int           p;
        err_w = '0;
        pc    = '0;
        for (int l = 0; l < PAR; l++) begin
            sum = '0;
            for (int i = 0; i <= T; i++) sum = sum ^ mulc(term_q[i], i * l);
            p = int'(beat_q) * PAR + l;
            err_w[l] = valid_q && (sum == '0) && (p < N);
            pc = pc + CW'(err_w[l]);
        end
    end

    always_comb begin
        term_d  = term_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        first_d = first_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        if (load) begin
            for (int i = 0; i <= T; i++)
                term_d[i] = mulc(sigma[i*M +: M], i * SHIFT);
            busy_d  = 1'b1;
            valid_d = 1'b1;
            first_d = 1'b1;
            beat_d  = '0;
            cnt_d   = '0;
        end else if (adv) begin
            for (int i = 0; i <= T; i++)
                term_d[i] = mulc(term_q[i], i * PAR);
            cnt_d   = cnt_q + pc;
            first_d = 1'b0;
            if (last_w) begin
                busy_d  = 1'b0;
                valid_d = 1'b0;
                beat_d  = '0;
            end else begin
                beat_d  = beat_q + BW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            term_q  <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            beat_q  <= '0;
            cnt_q   <= '0;
        end else begin
            term_q  <= term_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            first_q <= first_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy      = busy_q;
    assign valid     = valid_q;
    assign first     = first_q;
    assign last      = last_w;
    assign err       = err_w;
    // Count includes the beat currently presented
    assign err_count = cnt_q + pc;

`ifdef BCH_CHIEN_UNCORR_DETECT_EN
    localparam int DW = $clog2(T + 2);
    logic [DW-1:0] deg_q, deg_d;

    always_comb begin
        deg_d = deg_q;
        if (load) begin
            deg_d = '0;
            for (int i = 0; i <= T; i++)
                if (sigma[i*M +: M] != '0) deg_d = DW'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) deg_q <= '0;
        else        deg_q <= deg_d;
    end

    assign uncorr = last_w && (int'(cnt_q + pc) != int'(deg_q));
`else
    assign uncorr = 1'b0;
`endif

endmodule
